pattern_scan_engine: RTL and testbench
======================================

# pattern_scan_engine

Memory-mapped hardware accelerator for program 3 (5-bit pattern search over a 32-byte message). It sits beside data memory on the same read/write port the core uses. On a start pulse it:
- reads the pattern byte and the 32 message bytes;
- computes the three program-3 result counts;
- writes them back to data memory, then raises `done` for the top-level handshake.

Its results are the golden hardware values that the program-3 bench compares against the software run.

## Interface
Parameters:
- `ADDR_W`, 8, data-memory address width
- `MSG_BASE`, 0, address of message byte 0
- `MSG_LEN`, 32, number of message bytes
- `PAT_ADDR`, 32, pattern byte address; pattern is `[7:3]`
- `OUT_ADDR`, 33, first result address; results at `OUT_ADDR`..`OUT_ADDR+2`

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `req`  in  1  start request, sampled only in IDLE
- `done`  out  1  high in DONE until next accepted `req`
- `rd_addr`  out  `ADDR_W`  data-memory read address
- `rd_data`  in  8  read data, valid the cycle after `rd_addr` is presented (registered read)
- `wr_en`  out  1  one-cycle write strobe
- `wr_addr`  out  `ADDR_W`  write address
- `wr_data`  out  8  write data

## Operation
- FSM states: IDLE, RD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE.
- IDLE to RD_PAT on `req`=1. RD_PAT drives `rd_addr=PAT_ADDR`.
- SCAN issues `MSG_BASE+i` for i=0..31 on consecutive cycles.
  - Captures pattern on the first SCAN edge.
  - Processes byte i on the edge after its data returns.
  - One extra drain cycle, then leaves SCAN.
- Per byte b, in-byte windows are `b[7:3]`, `b[6:2]`, `b[5:1]`, `b[4:0]`:
  - `ctb` += number of windows equal to the pattern (0..4).
  - `cto` += 1 if any window matches.
- Crossing count `cts`: 256-bit string with byte 0 most significant.
  - Keep `prev4` = previous byte `[3:0]`.
  - For i≥1, additionally test the 4 windows spanning `{prev4,b}`: `{prev4[3:0],b[7]}`, `{prev4[2:0],b[7:6]}`, `{prev4[1:0],b[7:5]}`, `{prev4[0],b[7:4]}`.
  - `cts` = in-byte matches (all bytes) + spanning matches (bytes 1..31); 252 windows total.
- All counters are 8-bit. Maxima: `ctb` 128, `cto` 32, `cts` 252, so none can wrap.
- Write phase: WR_CTB writes `ctb`→`OUT_ADDR`, WR_CTO writes `cto`→`OUT_ADDR+1`, WR_CTS writes `cts`→`OUT_ADDR+2`. Then DONE.
- Counters and `prev4` clear on `req` acceptance, not on DONE exit, so results persist until restart.
- `req` in any non-IDLE, non-DONE state is ignored. `req` in DONE drops `done` and restarts at RD_PAT.

## Timing
- Reset values:
  - `done`=0, `wr_en`=0, `rd_addr`=0, `wr_addr`=0, `wr_data`=0.
  - State IDLE; counters 0.
- Reset asserted mid-operation: FSM returns to IDLE asynchronously, no further writes. A write strobe already asserted is dropped.
- Edge E0 samples `req`. RD_PAT occupies E0–E1. SCAN occupies E1–E34; byte 31 is processed at E34.
- Write edges: E35 (ctb), E36 (cto), E37 (cts). `done` is high from E37.
- Total latency: 37 edges from request sample to `done`.
- `wr_en` is high for exactly one cycle per result; never more than 3 strobes per run.
- `rd_addr` is held at its last value outside RD_PAT/SCAN.

## Configuration
- `PSE_CROSS_COUNT_EN` defined: crossing logic, `cts` and the WR_CTS state are present, as above.
- Undefined:
  - No `prev4` register or spanning compare.
  - WR_CTO goes directly to DONE, so `OUT_ADDR+2` is never written.
  - `done` rises at E36 (36-edge latency).

## Test plan
- All 32 bytes 0x00, pattern 0x00 → mem[33]=128, mem[34]=32, mem[35]=252; done at E37.
- All bytes 0x55, pattern 0xA8 (10101) → mem[33]=64, mem[34]=32, mem[35]=126.
- Byte 0 = 0xF8, others 0x00, pattern 0xF8 → mem[33]=1, mem[34]=1, mem[35]=1.
- Byte 0 = 0x0F, byte 1 = 0x80, others 0x00, pattern 0xF8 → mem[33]=0, mem[34]=0, mem[35]=1 (spanning only).
- Reset pulled low at E20 of a run, released, new `req` with data from the all-0x00 test → exactly 3 writes total, values 128/32/252; no writes before reset release.
- `req` held high during SCAN → no restart, single result set. Second `req` in DONE → `done` drops the next cycle, recomputed values rewritten.

Source files
------------

// File: rtl/pattern_scan_engine.sv
// pattern_scan_engine
//   Program-3 accelerator. After a start request it reads the pattern byte and
//   MSG_LEN message bytes over the data-memory port. It counts 5-bit pattern
//   matches and writes the result counts back to OUT_ADDR onwards, then holds
//   done high.
//
//   Optional feature: define PSE_CROSS_COUNT_EN to build the byte-crossing
//   count (cts), its prev4 register and the WR_CTS write state.
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   asynchronous, active-low
//   req      in   start request (accepted in IDLE or DONE)
//   done     out  results written; high until the next accepted req
//   rd_addr  out  data-memory read address (registered, holds outside reads)
//   rd_data  in   read data, valid the cycle after rd_addr is presented
//   wr_en    out  one-cycle write strobe per result
//   wr_addr  out  write address
//   wr_data  out  write data
module pattern_scan_engine #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MSG_BASE = 0,
  parameter int unsigned MSG_LEN  = 32,
  parameter int unsigned PAT_ADDR = 32,
  parameter int unsigned OUT_ADDR = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned CW = $clog2(MSG_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_PAT,
    SCAN,
    WR_CTB,
    WR_CTO,
`ifdef PSE_CROSS_COUNT_EN
    WR_CTS,
`endif
    DONE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   scan_cnt;
  logic [4:0]      pat;
  logic [7:0]      ctb, cto;
  logic [3:0]      hit_in;
  logic            accept;

`ifdef PSE_CROSS_COUNT_EN
  logic [7:0]      cts;
  logic [3:0]      prev4;
  logic [3:0]      hit_sp;
  logic [11:0]     span;
`endif

  function automatic logic [7:0] pop4(input logic [3:0] v);
    pop4 = 8'(v[0]) + 8'(v[1]) + 8'(v[2]) + 8'(v[3]);
  endfunction

  assign accept = req && (state == IDLE || state == DONE);

  // Window k of the current byte starts at bit 7-k; spanning windows take
  // the low nibble of the previous byte as their leading bits.
  always_comb begin
    hit_in = '0;
    for (int unsigned k = 0; k < 4; k++)
      hit_in[k] = (rd_data[7-k -: 5] == pat);
  end

`ifdef PSE_CROSS_COUNT_EN
  assign span = {prev4, rd_data};
  always_comb begin
    hit_sp = '0;
    for (int unsigned k = 0; k < 4; k++)
      hit_sp[k] = (span[11-k -: 5] == pat);
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req) state_nx = RD_PAT;
      RD_PAT:  state_nx = SCAN;
      SCAN:    if (scan_cnt == CW'(MSG_LEN)) state_nx = WR_CTB;
      WR_CTB:  state_nx = WR_CTO;
`ifdef PSE_CROSS_COUNT_EN
      WR_CTO:  state_nx = WR_CTS;
      WR_CTS:  state_nx = DONE;
`else
      WR_CTO:  state_nx = DONE;
`endif
      DONE:    if (req) state_nx = RD_PAT;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath. scan_cnt==0 is the pattern-capture edge. scan_cnt==n processes
  // byte n-1, because the read for byte n-1 was issued one cycle earlier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr  <= '0;
      scan_cnt <= '0;
      pat      <= '0;
      ctb      <= '0;
      cto      <= '0;
`ifdef PSE_CROSS_COUNT_EN
      cts      <= '0;
      prev4    <= '0;
`endif
    end else begin
      if (accept) begin
        rd_addr <= ADDR_W'(PAT_ADDR);
        ctb     <= '0;
        cto     <= '0;
`ifdef PSE_CROSS_COUNT_EN
        cts     <= '0;
        prev4   <= '0;
`endif
      end
      if (state == RD_PAT) begin
        rd_addr  <= ADDR_W'(MSG_BASE);
        scan_cnt <= '0;
      end
      if (state == SCAN) begin
        scan_cnt <= scan_cnt + 1'b1;
        if (scan_cnt < CW'(MSG_LEN - 1))
          rd_addr <= ADDR_W'(MSG_BASE + 32'(scan_cnt) + 1);
        if (scan_cnt == '0) begin
          pat <= rd_data[7:3];
        end else begin
          ctb <= ctb + pop4(hit_in);
          cto <= cto + 8'(|hit_in);
`ifdef PSE_CROSS_COUNT_EN
          // Spanning windows exist only once a previous byte has been seen.
          cts   <= cts + pop4(hit_in) +
                   ((scan_cnt > CW'(1)) ? pop4(hit_sp) : 8'd0);
          prev4 <= rd_data[3:0];
`endif
        end
      end
    end
  end

  // Outputs
  always_comb begin
    done    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state)
      WR_CTB: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(OUT_ADDR);
        wr_data = ctb;
      end
      WR_CTO: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(OUT_ADDR + 1);
        wr_data = cto;
      end
`ifdef PSE_CROSS_COUNT_EN
      WR_CTS: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(OUT_ADDR + 2);
        wr_data = cts;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Testbench for pattern_scan_engine: data-memory model with registered reads,
// a vector table run in a loop, and hand-written reset/hold/restart sequences.
// Expected writes go into a scoreboard queue when a request is issued. They
// are popped and compared whenever the DUT strobes wr_en.
module tb_pattern_scan_engine;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned MSG_BASE = 0;
  localparam int unsigned MSG_LEN  = 32;
  localparam int unsigned PAT_ADDR = 32;
  localparam int unsigned OUT_ADDR = 33;
`ifdef PSE_CROSS_COUNT_EN
  localparam int LAT = 37;
  localparam int NW  = 3;
`else
  localparam int LAT = 36;
  localparam int NW  = 2;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  logic [7:0] mem [256];

  pattern_scan_engine #(
    .ADDR_W  (ADDR_W),
    .MSG_BASE(MSG_BASE),
    .MSG_LEN (MSG_LEN),
    .PAT_ADDR(PAT_ADDR),
    .OUT_ADDR(OUT_ADDR)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .done   (done),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct {
    logic [255:0] msg;
    logic [7:0]   pat;
    int           ctb;
    int           cto;
    int           cts;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t tv[6];
  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Bit-string reference: slide a 5-bit window over the 256-bit message.
  // Offsets 0..3 inside a byte are in-byte windows; the rest span two bytes.
  function automatic void model(input logic [255:0] m, input logic [4:0] p,
                                output int ctb, output int cto, output int cts);
    logic [31:0] hit;
    ctb = 0; cto = 0; cts = 0; hit = '0;
    for (int j = 0; j < 252; j++) begin
      if (m[255-j -: 5] == p) begin
        cts++;
        if (j % 8 < 4) begin
          ctb++;
          hit[j/8] = 1'b1;
        end
      end
    end
    for (int b = 0; b < 32; b++) cto += int'(hit[b]);
  endfunction

  // Advance one clock and inspect any write strobe #1 after the edge.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(wr_addr), -1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(wr_addr), int'(e.addr));
        chk("wr_data", int'(wr_data), int'(e.data));
      end
    end
  endtask

  task automatic load(input int idx);
    for (int i = 0; i < 32; i++) mem[MSG_BASE + i] = tv[idx].msg[255-8*i -: 8];
    mem[PAT_ADDR] = tv[idx].pat;
  endtask

  task automatic push_exp(input int idx);
    exp_q.push_back('{addr: 8'(OUT_ADDR),     data: 8'(tv[idx].ctb)});
    exp_q.push_back('{addr: 8'(OUT_ADDR + 1), data: 8'(tv[idx].cto)});
`ifdef PSE_CROSS_COUNT_EN
    exp_q.push_back('{addr: 8'(OUT_ADDR + 2), data: 8'(tv[idx].cts)});
`endif
  endtask

  task automatic run_vec(input int idx, input bit hold);
    int n;
    int w0;
    load(idx);
    push_exp(idx);
    w0 = wr_count;
    req = 1'b1;
    tick();                       // E0: request sampled
    if (!hold) req = 1'b0;
    chk("done_low_after_accept", int'(done), 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 100);
    req = 1'b0;
    chk("latency", done ? n : -1, LAT);
    chk("write_count", wr_count - w0, NW);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int w0;
    int a, b, c;
    logic [255:0] r1, r2;

    // Vector table: test-plan cases as constants, random cases from the model.
    tv[0] = '{msg: {32{8'h00}}, pat: 8'h00, ctb: 128, cto: 32, cts: 252};
    tv[1] = '{msg: {32{8'h55}}, pat: 8'hA8, ctb: 64,  cto: 32, cts: 126};
    tv[2] = '{msg: {8'hF8, {31{8'h00}}}, pat: 8'hF8, ctb: 1, cto: 1, cts: 1};
    tv[3] = '{msg: {8'h0F, 8'h80, {30{8'h00}}}, pat: 8'hF8, ctb: 0, cto: 0, cts: 1};
    for (int w = 0; w < 8; w++) begin
      r1[w*32 +: 32] = $urandom;
      r2[w*32 +: 32] = $urandom & $urandom;
    end
    model(r1, 5'b10110, a, b, c);
    tv[4] = '{msg: r1, pat: 8'hB0, ctb: a, cto: b, cts: c};
    model(r2, 5'b00000, a, b, c);
    tv[5] = '{msg: r2, pat: 8'h07, ctb: a, cto: b, cts: c};

    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;

    // Asynchronous reset: outputs clear before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk("rst_done",    int'(done),    0);
    chk("rst_wr_en",   int'(wr_en),   0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("idle_no_done", int'(done), 0);

    for (int i = 0; i < 6; i++) run_vec(i, 1'b0);

    // Reset mid-scan at E20: no writes from the aborted run, then a clean rerun.
    w0 = wr_count;
    load(0);
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (20) tick();
    chk("scan_rd_addr_nonzero", int'(rd_addr != '0), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_rd_addr", int'(rd_addr), 0);
    chk("abort_wr_en",   int'(wr_en),   0);
    chk("abort_done",    int'(done),    0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("abort_no_writes", wr_count - w0, 0);
    run_vec(0, 1'b0);
    chk("abort_total_writes", wr_count - w0, NW);

    // req held through SCAN and the write phase: one result set only.
    run_vec(1, 1'b1);
    w0 = wr_count;
    repeat (5) tick();
    chk("hold_done_stays", int'(done), 1);
    chk("hold_no_extra_writes", wr_count - w0, 0);

    // Restart from DONE with new data: counters cleared, results recomputed.
    run_vec(3, 1'b0);
    run_vec(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
